// File: rtl/pll_reset_seq_if.sv
// pll_reset_seq_if: lock input and reset/status outputs of the PLL reset sequencer.
//   locked        : PLL lock flag (asynchronous to the sequencer clock)
//   rst_out       : active-high stage resets, one bit per stage
//   ready         : high once every stage is released
//   lock_loss_cnt : saturating lock-loss count (only with PLL_RESET_SEQ_LOSS_CNT_EN)
// The master modport is the sequencer side and the slave modport is the consumer/PLL side.
interface pll_reset_seq_if #(
    parameter int unsigned NUM_STAGES = 3
);
    logic                  locked;
    logic [NUM_STAGES-1:0] rst_out;
    logic                  ready;
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic [7:0]            lock_loss_cnt;

    modport master (input locked, output rst_out, output ready, output lock_loss_cnt);
    modport slave  (output locked, input rst_out, input ready, input lock_loss_cnt);
`else
    modport master (input locked, output rst_out, output ready);
    modport slave  (output locked, input rst_out, input ready);
`endif
endinterface

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: multi-stage reset sequencer downstream of the PLL.
// It synchronizes the PLL lock flag and holds all stage resets until lock has
// been stable for LOCK_CYCLES. It then releases the stages in index order,
// STAGE_GAP cycles apart. Lock lost for GLITCH_MAX cycles in RUN, or any lock
// drop during RELEASE, re-asserts every stage.
// Ports:
//   clk   : PLL output clock
//   reset : synchronous, active-high
//   bus   : pll_reset_seq_if.master (locked in, rst_out/ready out)
// Optional feature: define PLL_RESET_SEQ_LOSS_CNT_EN to build the 8-bit
// saturating lock_loss_cnt output.
module pll_reset_seq #(
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned STAGE_GAP   = 16,
    parameter int unsigned GLITCH_MAX  = 4
) (
    input  logic            clk,
    input  logic            reset,
    pll_reset_seq_if.master bus
);
    localparam int unsigned SETTLE_W = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned IDX_W    = $clog2(NUM_STAGES + 1);
    localparam int unsigned GAP_W    = 8;
    localparam int unsigned GLITCH_W = 4;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                state_q;
    logic                  s1_q;
    logic                  s2_q;
    logic [SETTLE_W-1:0]   settle_cnt_q;
    logic [GAP_W-1:0]      gap_cnt_q;
    logic [IDX_W-1:0]      stage_idx_q;
    logic [GLITCH_W-1:0]   glitch_cnt_q;
    logic [NUM_STAGES-1:0] rst_out_q;
    logic                  ready_q;
    logic                  locked_s;
    logic [NUM_STAGES-1:0] stage_bit_c;

    assign locked_s = s2_q;

    // One-hot mask for the stage that the next gap expiry releases.
    always_comb begin
        stage_bit_c = '0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            if (IDX_W'(i) == stage_idx_q) begin
                stage_bit_c[i] = 1'b1;
            end
        end
    end

    // Lock synchronizer, sequencing FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            state_q      <= WAIT_LOCK;
            settle_cnt_q <= '0;
            gap_cnt_q    <= '0;
            stage_idx_q  <= '0;
            glitch_cnt_q <= '0;
            rst_out_q    <= '1;
            ready_q      <= 1'b0;
        end else begin
            s1_q <= bus.locked;
            s2_q <= s1_q;
            case (state_q)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_q      <= SETTLE;
                        settle_cnt_q <= '0;
                    end
                end
                SETTLE: begin
                    if (!locked_s) begin
                        // Any low sample restarts the whole stability wait.
                        state_q      <= WAIT_LOCK;
                        settle_cnt_q <= '0;
                    end else if (settle_cnt_q == SETTLE_W'(LOCK_CYCLES - 1)) begin
                        rst_out_q[0] <= 1'b0;
                        gap_cnt_q    <= '0;
                        stage_idx_q  <= IDX_W'(1);
                        if (NUM_STAGES == 1) begin
                            state_q      <= RUN;
                            ready_q      <= 1'b1;
                            glitch_cnt_q <= '0;
                        end else begin
                            state_q <= RELEASE;
                        end
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SETTLE_W'(1);
                    end
                end
                RELEASE: begin
                    if (!locked_s) begin
                        // No debounce while stages are coming out of reset.
                        state_q   <= WAIT_LOCK;
                        rst_out_q <= '1;
                        ready_q   <= 1'b0;
                    end else if (gap_cnt_q == GAP_W'(STAGE_GAP - 1)) begin
                        rst_out_q   <= rst_out_q & ~stage_bit_c;
                        stage_idx_q <= stage_idx_q + IDX_W'(1);
                        gap_cnt_q   <= '0;
                        if (stage_idx_q == IDX_W'(NUM_STAGES - 1)) begin
                            state_q      <= RUN;
                            ready_q      <= 1'b1;
                            glitch_cnt_q <= '0;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                RUN: begin
                    if (locked_s) begin
                        glitch_cnt_q <= '0;
                    end else if (glitch_cnt_q == GLITCH_W'(GLITCH_MAX - 1)) begin
                        state_q      <= WAIT_LOCK;
                        rst_out_q    <= '1;
                        ready_q      <= 1'b0;
                        glitch_cnt_q <= '0;
                    end else begin
                        glitch_cnt_q <= glitch_cnt_q + GLITCH_W'(1);
                    end
                end
                default: begin
                    state_q   <= WAIT_LOCK;
                    rst_out_q <= '1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rst_out = rst_out_q;
    assign bus.ready   = ready_q;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic       loss_c;
    logic [7:0] loss_cnt_q;
    logic [7:0] loss_cnt_d;

    // A loss is a lock drop in RELEASE, or the debounce expiring in RUN.
    always_comb begin
        loss_c     = 1'b0;
        loss_cnt_d = loss_cnt_q;
        if (!locked_s) begin
            if (state_q == RELEASE) begin
                loss_c = 1'b1;
            end else if (state_q == RUN && glitch_cnt_q == GLITCH_W'(GLITCH_MAX - 1)) begin
                loss_c = 1'b1;
            end
        end
        if (loss_c && loss_cnt_q != 8'hFF) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    // Reset takes priority over a simultaneous loss event.
    always_ff @(posedge clk) begin
        if (reset) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign bus.lock_loss_cnt = loss_cnt_q;
`endif
endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset sequencer that sits directly downstream of the iCE40 PLL wrapper. It runs on the PLL output clock and synchronizes the PLL `locked` flag. It holds a multi-stage active-high reset until lock has been continuously stable for a programmable time, then releases the stages one at a time at fixed spacing. It re-asserts all stages if lock is lost for longer than a debounce window.

## Interface
- `LOCK_CYCLES`, default 1024: consecutive synchronized-lock cycles required before release. Range 1..65535.
- `NUM_STAGES`, default 3: number of reset outputs, released in index order. Range 1..8.
- `STAGE_GAP`, default 16: cycles between successive stage releases. Range 1..255.
- `GLITCH_MAX`, default 4: consecutive low-lock cycles in RUN that trigger re-reset. Range 1..15.
- `clk`  in  1: PLL output clock; the sole clock.
- `reset`  in  1: synchronous, active-high; forces the block to its reset state.
- `locked`  in  1: PLL lock flag, asynchronous to `clk`.
- `rst_out`  out  NUM_STAGES: active-high stage resets, registered.
- `ready`  out  1: high when all stages are released, registered.
- `lock_loss_cnt`  out  8: saturating count of lock-loss events. Present only with `PLL_RESET_SEQ_LOSS_CNT_EN`.

## Operation
- `locked` passes through a 2-FF synchronizer (`s1`, `s2`); all logic uses `locked_s = s2`. Synchronizer flops reset to 0.
- States: WAIT_LOCK, SETTLE, RELEASE, RUN.
- `reset`=1 at an edge sets: state WAIT_LOCK, all counters 0, `rst_out` all ones, `ready`=0, `lock_loss_cnt`=0. This applies from any state, including mid-RELEASE.
- WAIT_LOCK: when `locked_s`=1, go to SETTLE with `settle_cnt`=0.
- SETTLE:
  - `locked_s`=0: go to WAIT_LOCK (no loss count).
  - Otherwise `settle_cnt` increments.
  - At the edge where `settle_cnt`==LOCK_CYCLES-1 and `locked_s`=1: go to RELEASE, clear `rst_out[0]`, set `gap_cnt`=0 and `stage_idx`=1.
  - `settle_cnt` width is clog2(LOCK_CYCLES+1).
- RELEASE:
  - `gap_cnt` increments each cycle.
  - When `gap_cnt`==STAGE_GAP-1: clear `rst_out[stage_idx]`, increment `stage_idx`, zero `gap_cnt`.
  - On the edge that clears stage NUM_STAGES-1: go to RUN and set `ready`=1.
  - NUM_STAGES=1: go straight from SETTLE to RUN with `ready`=1 on the same edge that clears `rst_out[0]`.
  - `locked_s`=0 during RELEASE: on that edge go to WAIT_LOCK, set `rst_out` all ones and `ready`=0. No debounce applies. The event counts as a loss.
- RUN:
  - `glitch_cnt` counts consecutive `locked_s`=0 cycles; any `locked_s`=1 cycle clears it.
  - When `locked_s`=0 and `glitch_cnt`==GLITCH_MAX-1: go to WAIT_LOCK, set `rst_out` all ones, `ready`=0, and count a loss.
- Stages are only ever released in ascending index order. On re-reset, all stages assert together.
- `lock_loss_cnt` increments by 1 per loss event and saturates at 255.
- If `reset` and a loss event occur on the same edge, `reset` wins and the counter goes to 0.

## Timing
- Let E0 be the first `clk` edge that samples `locked`=1 into `s1`. Then:
  - `locked_s`=1 after E1.
  - SETTLE entered at E2.
  - `rst_out[0]` falls at E(LOCK_CYCLES+2).
  - `rst_out[k]` falls at E(LOCK_CYCLES+2+k·STAGE_GAP).
  - `ready` rises together with the last stage.
- Let F0 be the first edge that samples `locked`=0 while in RUN. `rst_out` reasserts and `ready` falls at F(GLITCH_MAX+1).
- A low pulse on `locked` shorter than GLITCH_MAX sampled cycles causes no output change in RUN.
- A single low sample in SETTLE restarts the full LOCK_CYCLES wait.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `PLL_RESET_SEQ_LOSS_CNT_EN` defined: the `lock_loss_cnt` port and its 8-bit saturating counter exist.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- `reset` for 3 cycles, `locked`=0 -> `rst_out`=all ones, `ready`=0, `lock_loss_cnt`=0 indefinitely.
- LOCK_CYCLES=8, NUM_STAGES=3, STAGE_GAP=4; raise `locked` at E0 -> `rst_out[0]` falls at E10, `[1]` at E14, `[2]` at E18, and `ready`=1 at E18.
- Same config; drop `locked` for 1 sample at E6 during SETTLE -> no release at E10; the full wait restarts and `rst_out[0]` falls 8 cycles after `locked_s` returns plus the sync/WAIT_LOCK latency.
- In RUN with GLITCH_MAX=4: a 3-cycle low pulse -> no change. A 4-cycle low starting at F0 -> `rst_out`=3'b111 and `ready`=0 at F5, `lock_loss_cnt`=1.
- `locked` drop during RELEASE after stage 0 -> all stages reassert on the following edge and `lock_loss_cnt` increments. 260 forced losses -> `lock_loss_cnt` holds at 255.
- Assert `reset` mid-RELEASE, with `locked` held at 1 -> immediate return to all-ones; the sequence repeats from WAIT_LOCK with the E(LOCK_CYCLES+2) timing measured from `reset` deassertion.
